// File: rtl/gb_capture_ctrl.sv
// Game Boy LCD capture controller: synchronises and filters the LCD bus,
// turns pixel clock edges into framebuffer writes, checks frame geometry
// and rotates three framebuffer banks so scan-out only sees whole frames.
module gb_capture_ctrl #(
  parameter int H_PIXELS   = 160,
  parameter int V_LINES    = 144,
  parameter int FILTER_LEN = 2,
  parameter int PIX_W      = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iclk,
  input  logic             ihsync,
  input  logic             ivsync,
  input  logic [1:0]       idata,
  input  logic             vblank,
  output logic             wr_en,
  output logic [PIX_W+1:0] wr_addr,
  output logic [1:0]       wr_data,
  output logic [1:0]       rd_bank,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [7:0]       skip_count
);

  localparam int XW = $clog2(H_PIXELS + 2);
  localparam int YW = $clog2(V_LINES + 1);

  localparam logic [XW-1:0]    H_X      = XW'(H_PIXELS);
  localparam logic [XW-1:0]    X_ONE    = XW'(1);
  localparam logic [YW-1:0]    V_Y      = YW'(V_LINES);
  localparam logic [YW-1:0]    Y_ONE    = YW'(1);
  localparam logic [PIX_W-1:0] LB_STEP  = PIX_W'(H_PIXELS);
  localparam logic [3:0]       CNT_LAST = 4'(FILTER_LEN - 1);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_CAPTURE = 1'b1;

  // Channel order for the control lines: 0 = iclk, 1 = ihsync, 2 = ivsync.
  logic [2:0] ctl_s1_reg, ctl_s2_reg;
  logic [1:0] dat_s1_reg, dat_s2_reg;
  logic [2:0] ctl_filt;
  logic [2:0] filt_prev_reg;

  // Two-flop synchronisers for every asynchronous LCD input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_s1_reg <= 3'b111;
      ctl_s2_reg <= 3'b111;
      dat_s1_reg <= 2'b00;
      dat_s2_reg <= 2'b00;
    end else begin
      ctl_s1_reg <= {ivsync, ihsync, iclk};
      ctl_s2_reg <= ctl_s1_reg;
      dat_s1_reg <= idata;
      dat_s2_reg <= dat_s1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_filt
      logic       f_reg;
      logic [3:0] cnt_reg;
      // Filtered level flips only after FILTER_LEN consecutive differing samples.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          f_reg   <= 1'b1;
          cnt_reg <= 4'd0;
        end else if (ctl_s2_reg[gi] == f_reg) begin
          cnt_reg <= 4'd0;
        end else if (cnt_reg == CNT_LAST) begin
          f_reg   <= ctl_s2_reg[gi];
          cnt_reg <= 4'd0;
        end else begin
          cnt_reg <= cnt_reg + 4'd1;
        end
      end
      assign ctl_filt[gi] = f_reg;
    end
  endgenerate

  logic pix_det, line_det, frame_det;
  assign pix_det   = filt_prev_reg[0] & ~ctl_filt[0] & ~ctl_filt[1];
  assign line_det  = ~filt_prev_reg[1] & ctl_filt[1];
  assign frame_det = ~filt_prev_reg[2] & ctl_filt[2];

  logic       pix_ev_reg, line_ev_reg, frame_ev_reg;
  logic [1:0] pix_data_reg;

  // Register decoded edge events with the pixel value seen at detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_prev_reg <= 3'b111;
      pix_ev_reg    <= 1'b0;
      line_ev_reg   <= 1'b0;
      frame_ev_reg  <= 1'b0;
      pix_data_reg  <= 2'b00;
    end else begin
      filt_prev_reg <= ctl_filt;
      pix_ev_reg    <= pix_det;
      line_ev_reg   <= line_det;
      frame_ev_reg  <= frame_det;
      pix_data_reg  <= ~dat_s2_reg;
    end
  end

  logic [0:0]       state_reg, state_next;
  logic [XW-1:0]    x_reg, x_next;
  logic [YW-1:0]    y_reg, y_next;
  logic [PIX_W-1:0] line_base_reg, line_base_next;
  logic             bad_reg, bad_next;
  logic [1:0]       w_reg, w_next, r_reg, r_next, d_reg, d_next;
  logic             rv_reg, rv_next;
  logic [7:0]       skip_reg, skip_next;
  logic             wr_en_reg, wr_en_next;
  logic [PIX_W+1:0] wr_addr_reg, wr_addr_next;
  logic [1:0]       wr_data_reg, wr_data_next;
  logic             ok_reg, ok_next, err_reg, err_next;
  logic             complete;
  logic [1:0]       d_mid;
  logic             rv_mid;

  // Capture FSM, geometry check and bank rotation (vblank applied before completion).
  always_comb begin
    state_next     = state_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    line_base_next = line_base_reg;
    bad_next       = bad_reg;
    wr_en_next     = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    ok_next        = 1'b0;
    err_next       = 1'b0;
    complete       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (frame_ev_reg) begin
          state_next     = ST_CAPTURE;
          x_next         = '0;
          y_next         = '0;
          line_base_next = '0;
          bad_next       = 1'b0;
        end
      end
      default: begin
        if (frame_ev_reg) begin
          // Early vsync: drop this frame and restart in the same bank.
          err_next       = 1'b1;
          x_next         = '0;
          y_next         = '0;
          line_base_next = '0;
          bad_next       = 1'b0;
        end else begin
          if (pix_ev_reg) begin
            if (x_reg < H_X) begin
              wr_en_next   = 1'b1;
              wr_addr_next = {w_reg, line_base_reg + PIX_W'(x_reg)};
              wr_data_next = pix_data_reg;
              x_next       = x_reg + X_ONE;
            end else begin
              bad_next = 1'b1;
            end
          end
          if (line_ev_reg && (x_next != '0)) begin
            if (x_next != H_X) begin
              bad_next = 1'b1;
            end
            x_next         = '0;
            y_next         = y_reg + Y_ONE;
            line_base_next = line_base_reg + LB_STEP;
            if (y_next == V_Y) begin
              complete   = 1'b1;
              state_next = ST_IDLE;
            end
          end
        end
      end
    endcase

    d_mid  = d_reg;
    rv_mid = rv_reg;
    if (vblank && rv_reg) begin
      d_mid  = r_reg;
      rv_mid = 1'b0;
    end
    d_next    = d_mid;
    rv_next   = rv_mid;
    r_next    = r_reg;
    w_next    = w_reg;
    skip_next = skip_reg;

    if (complete) begin
      if (bad_next) begin
        err_next = 1'b1;
      end else begin
        ok_next = 1'b1;
        r_next  = w_reg;
        if (!rv_mid) begin
          // The free bank is whichever of 0..2 is neither displayed nor written.
          w_next  = 2'd3 - d_mid - w_reg;
          rv_next = 1'b1;
        end else begin
          w_next = r_reg;
          if (skip_reg != 8'hff) begin
            skip_next = skip_reg + 8'd1;
          end
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      line_base_reg <= '0;
      bad_reg       <= 1'b0;
      w_reg         <= 2'd1;
      r_reg         <= 2'd0;
      d_reg         <= 2'd0;
      rv_reg        <= 1'b0;
      skip_reg      <= 8'd0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= 2'b00;
      ok_reg        <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      line_base_reg <= line_base_next;
      bad_reg       <= bad_next;
      w_reg         <= w_next;
      r_reg         <= r_next;
      d_reg         <= d_next;
      rv_reg        <= rv_next;
      skip_reg      <= skip_next;
      wr_en_reg     <= wr_en_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      ok_reg        <= ok_next;
      err_reg       <= err_next;
    end
  end

  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign rd_bank    = d_reg;
  assign frame_ok   = ok_reg;
  assign frame_err  = err_reg;
  assign skip_count = skip_reg;

endmodule

// File: tb/tb_gb_capture_ctrl.sv
// Testbench for gb_capture_ctrl. Uses a reduced frame geometry so whole
// frames stay short; writes are checked against a scoreboard queue filled
// as pixels are driven, and bank/pulse state is checked after each scenario.
module tb_gb_capture_ctrl;

  localparam int H  = 8;
  localparam int V  = 6;
  localparam int FL = 2;
  localparam int PW = 6;
  localparam int AW = PW + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          iclk, ihsync, ivsync;
  logic [1:0]    idata;
  logic          vblank;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_data;
  logic [1:0]    rd_bank;
  logic          frame_ok, frame_err;
  logic [7:0]    skip_count;

  always #5 clk = ~clk;

  gb_capture_ctrl #(
    .H_PIXELS(H), .V_LINES(V), .FILTER_LEN(FL), .PIX_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .iclk(iclk), .ihsync(ihsync), .ivsync(ivsync),
    .idata(idata), .vblank(vblank), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_bank(rd_bank), .frame_ok(frame_ok),
    .frame_err(frame_err), .skip_count(skip_count)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    data;
  } wr_t;

  typedef struct {
    logic [1:0] idata;
    logic [1:0] exp_data;
  } vec_t;

  wr_t  sb_q[$];
  vec_t vecs[6];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_count = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int last_wr_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One negedge: sample outputs, pop the scoreboard on writes, count pulses.
  task automatic tick(input int n);
    wr_t e;
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (wr_en) begin
        wr_count++;
        last_wr_cyc = cyc;
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0d expected no write", wr_addr, wr_data);
        end else begin
          e = sb_q.pop_front();
          if (wr_addr !== e.addr || wr_data !== e.data) begin
            n_fail++;
            $display("FAIL write: got addr %0h data %0d expected addr %0h data %0d",
                     wr_addr, wr_data, e.addr, e.data);
          end
        end
      end
      if (frame_ok)  ok_cnt++;
      if (frame_err) err_cnt++;
    end
  endtask

  task automatic idle_inputs();
    iclk = 1'b1; ihsync = 1'b1; ivsync = 1'b1; idata = 2'b00; vblank = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle_inputs();
    tick(3);
    sb_q.delete();
    rst = 1'b0;
    tick(3);
  endtask

  task automatic push_wr(input logic [1:0] bank, input int idx, input logic [1:0] d);
    wr_t e;
    e.addr = {bank, PW'(idx)};
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic pixel(input logic [1:0] d, input logic [1:0] exp_d, input bit expect_wr,
                       input logic [1:0] bank, input int idx);
    if (expect_wr) push_wr(bank, idx, exp_d);
    iclk = 1'b0;
    idata = d;
    tick(2);
    iclk = 1'b1;
    tick(3);
  endtask

  task automatic frame_start();
    ivsync = 1'b0;
    tick(3);
    ivsync = 1'b1;
    tick(6);
  endtask

  task automatic line_pixels(input int npix, input logic [1:0] bank, input int base);
    logic [1:0] d;
    ihsync = 1'b0;
    tick(3);
    for (int i = 0; i < npix; i++) begin
      d = 2'(base + i * 3);
      pixel(d, ~d, i < H, bank, base + i);
    end
  endtask

  task automatic send_line(input int npix, input logic [1:0] bank, input int base);
    line_pixels(npix, bank, base);
    ihsync = 1'b1;
    tick(6);
  endtask

  task automatic send_lines(input int first, input int nlines, input logic [1:0] bank,
                            input int bad_line);
    for (int l = first; l < first + nlines; l++)
      send_line((l == bad_line) ? H + 1 : H, bank, l * H);
    tick(2);
  endtask

  task automatic pulse_vblank();
    vblank = 1'b1;
    tick(1);
    vblank = 1'b0;
    tick(2);
  endtask

  int base_ok, base_err, base_wr, low_cyc;

  initial begin
    vecs[0] = '{2'b00, 2'b11};
    vecs[1] = '{2'b11, 2'b00};
    vecs[2] = '{2'b10, 2'b01};
    vecs[3] = '{2'b01, 2'b10};
    vecs[4] = '{2'b11, 2'b00};
    vecs[5] = '{2'b00, 2'b11};

    rst = 1'b1;
    idle_inputs();
    reset_dut();

    // Reset state.
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_rd_bank", int'(rd_bank), 0);
    check("rst_skip", int'(skip_count), 0);
    check("rst_w", int'(dut.w_reg), 1);
    check("rst_rv", int'(dut.rv_reg), 0);

    // One clean frame into bank 1, then display it.
    base_wr = wr_count;
    frame_start();
    send_lines(0, V, 2'd1, -1);
    $display("[TB] clean frame: writes=%0d ok=%0d", wr_count - base_wr, ok_cnt);
    check("clean_writes", wr_count - base_wr, H * V);
    check("clean_ok", ok_cnt, 1);
    check("clean_err", err_cnt, 0);
    check("clean_r", int'(dut.r_reg), 1);
    check("clean_w", int'(dut.w_reg), 2);
    pulse_vblank();
    check("clean_rd_bank", int'(rd_bank), 1);
    check("clean_rv_after_vb", int'(dut.rv_reg), 0);

    // Glitch rejection, write latency and data inversion.
    reset_dut();
    frame_start();
    ihsync = 1'b0;
    tick(3);
    base_wr = wr_count;
    iclk = 1'b0;
    tick(1);
    iclk = 1'b1;
    tick(6);
    check("glitch_no_write", wr_count - base_wr, 0);
    push_wr(2'd1, 0, 2'b10);
    iclk = 1'b0;
    idata = 2'b01;
    low_cyc = cyc + 1;
    tick(2);
    iclk = 1'b1;
    tick(6);
    $display("[TB] two-cycle low: write seen %0d cycles after first low sample", last_wr_cyc - low_cyc);
    check("pix_one_write", wr_count - base_wr, 1);
    check("pix_latency", last_wr_cyc - low_cyc, FL + 3);
    for (int k = 0; k < 6; k++) begin
      pixel(vecs[k].idata, vecs[k].exp_data, 1'b1, 2'd1, k + 1);
      $display("[TB] vec %0d idata=%0d wr_data=%0d", k, vecs[k].idata, wr_data);
    end
    tick(4);
    check("vec_drained", sb_q.size(), 0);

    // Overlong line: extra pixel suppressed, frame rejected.
    reset_dut();
    base_wr = wr_count; base_ok = ok_cnt; base_err = err_cnt;
    frame_start();
    send_lines(0, V, 2'd1, 2);
    check("bad_writes", wr_count - base_wr, H * V);
    check("bad_err", err_cnt - base_err, 1);
    check("bad_ok", ok_cnt - base_ok, 0);
    check("bad_w", int'(dut.w_reg), 1);
    check("bad_rv", int'(dut.rv_reg), 0);

    // Early vsync: rejected, next capture restarts at bank 1 address 0.
    base_err = err_cnt;
    frame_start();
    send_lines(0, V - 2, 2'd1, -1);
    frame_start();
    tick(2);
    check("early_err", err_cnt - base_err, 1);
    base_ok = ok_cnt;
    send_lines(0, V, 2'd1, -1);
    check("early_then_ok", ok_cnt - base_ok, 1);
    check("early_then_w", int'(dut.w_reg), 2);

    // Two frames without vblank: second overwrites the ready frame.
    reset_dut();
    frame_start();
    send_lines(0, V, 2'd1, -1);
    frame_start();
    send_lines(0, V, 2'd2, -1);
    check("skip_count", int'(skip_count), 1);
    check("skip_r", int'(dut.r_reg), 2);
    check("skip_w", int'(dut.w_reg), 1);
    check("skip_d", int'(rd_bank), 0);
    pulse_vblank();
    check("skip_rd_bank", int'(rd_bank), 2);

    // Completion and vblank landing on the same clock edge.
    reset_dut();
    base_ok = ok_cnt;
    frame_start();
    send_lines(0, V, 2'd1, -1);
    frame_start();
    send_lines(0, V - 1, 2'd2, -1);
    line_pixels(H, 2'd2, (V - 1) * H);
    ihsync = 1'b1;
    tick(5);
    vblank = 1'b1;
    tick(1);
    vblank = 1'b0;
    tick(3);
    check("coinc_ok", ok_cnt - base_ok, 2);
    check("coinc_d", int'(rd_bank), 1);
    check("coinc_r", int'(dut.r_reg), 2);
    check("coinc_w", int'(dut.w_reg), 0);
    check("coinc_rv", int'(dut.rv_reg), 1);
    check("coinc_skip", int'(skip_count), 0);

    // Reset part-way through a frame.
    reset_dut();
    frame_start();
    send_lines(0, 3, 2'd1, -1);
    line_pixels(3, 2'd1, 3 * H);
    tick(4);
    check("pre_rst_addr", int'(wr_addr), int'({2'd1, PW'(3 * H + 2)}));
    #2;
    rst = 1'b1;
    #1;
    check("async_wr_en", int'(wr_en), 0);
    check("async_wr_addr", int'(wr_addr), 0);
    check("async_wr_data", int'(wr_data), 0);
    check("async_rd_bank", int'(rd_bank), 0);
    check("async_ok", int'(frame_ok), 0);
    idle_inputs();
    tick(3);
    sb_q.delete();
    rst = 1'b0;
    tick(3);
    base_ok = ok_cnt;
    frame_start();
    send_lines(0, V, 2'd1, -1);
    check("post_rst_ok", ok_cnt - base_ok, 1);
    check("post_rst_r", int'(dut.r_reg), 1);
    check("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
